// File: rtl/flattener_pkg.sv
// -----------------------------------------------------------------------------
// flattener_pkg
// Shared types and width helpers for the feature_flattener block.
//   bank_state_t  : life cycle of one ping-pong bank
//   drain_state_t : states of the output (drain) FSM
//   safe_clog2 / pix_width / word_width : counter/address widths, never 0
// -----------------------------------------------------------------------------
package flattener_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } drain_state_t;

  // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit counter
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the per-bank pixel counter (Pixels = FeatureWidth**2)
  function automatic int pix_width(input int feature_width);
    return safe_clog2(feature_width * feature_width);
  endfunction

  // Width of a bank word address (Words = NumberOfK * Pixels)
  function automatic int word_width(input int number_of_k, input int feature_width);
    return safe_clog2(number_of_k * feature_width * feature_width);
  endfunction

endpackage

// File: rtl/feature_flattener_if.sv
// -----------------------------------------------------------------------------
// feature_flattener_if
// Bundles the upstream feature stream and the downstream serial stream.
//   in_valid  : per-kernel valid from conv_pooling_top
//   in_data   : ProcessingElements lanes of BitSize bits
//   in_ready  : a bank is free for writing
//   out_valid / out_data / out_last / out_ready : serial valid/ready stream
// Modports:
//   master : the environment (drives inputs, consumes outputs)
//   slave  : the flattener itself
// -----------------------------------------------------------------------------
interface feature_flattener_if #(
  parameter int BitSize            = 4,
  parameter int NumberOfK          = 8,
  parameter int ProcessingElements = 2
);

  logic [NumberOfK-1:0]                         in_valid;
  logic [ProcessingElements-1:0][BitSize-1:0]   in_data;
  logic                                         in_ready;
  logic                                         out_valid;
  logic [BitSize-1:0]                           out_data;
  logic                                         out_last;
  logic                                         out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/feature_bank.sv
// -----------------------------------------------------------------------------
// feature_bank
// One ping-pong bank: Words x BitSize flop array with ProcessingElements
// independent write ports and one combinational read port.
//   clk     : clock
//   wr_en   : per-lane write enable
//   wr_addr : per-lane word address
//   wr_data : per-lane write data
//   rd_addr : read address
//   rd_data : combinational read data
// Lanes always carry distinct kernels, so two lanes never hit the same word.
// -----------------------------------------------------------------------------
module feature_bank
  import flattener_pkg::*;
#(
  parameter int BitSize            = 4,
  parameter int Words              = 32,
  parameter int ProcessingElements = 2,
  parameter int AddrWidth          = safe_clog2(Words)
) (
  input  logic                                       clk,
  input  logic [ProcessingElements-1:0]              wr_en,
  input  logic [ProcessingElements-1:0][AddrWidth-1:0] wr_addr,
  input  logic [ProcessingElements-1:0][BitSize-1:0] wr_data,
  input  logic [AddrWidth-1:0]                       rd_addr,
  output logic [BitSize-1:0]                         rd_data
);

  logic [BitSize-1:0] mem [Words];

  always_ff @(posedge clk) begin
    for (int p = 0; p < ProcessingElements; p++) begin
      if (wr_en[p]) begin
        mem[wr_addr[p]] <= wr_data[p];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/feature_flattener.sv
// -----------------------------------------------------------------------------
// feature_flattener
// Captures one pooled frame of multi-lane per-kernel features into a ping-pong
// bank and re-emits it as a single-lane, channel-major serial stream.
//   clk   : clock
//   res_n : synchronous active-low reset
//   bus   : feature_flattener_if.slave (in_valid/in_data/in_ready upstream,
//           out_valid/out_data/out_last/out_ready downstream)
// All outputs are registered except in_ready, which decodes registered state.
// -----------------------------------------------------------------------------
module feature_flattener
  import flattener_pkg::*;
#(
  parameter int BitSize            = 4,
  parameter int NumberOfK          = 8,
  parameter int ProcessingElements = 2,
  parameter int FeatureWidth       = 2
) (
  input logic          clk,
  input logic          res_n,
  feature_flattener_if.slave bus
);

  localparam int CyclesPerPixel = NumberOfK / ProcessingElements;
  localparam int Pixels         = FeatureWidth * FeatureWidth;
  localparam int Words          = NumberOfK * Pixels;
  localparam int PixW           = pix_width(FeatureWidth);
  localparam int WordW          = word_width(NumberOfK, FeatureWidth);
  localparam int GrpW           = safe_clog2(CyclesPerPixel);

  bank_state_t                 bank_state_reg [2];
  logic                        fill_ptr_reg;
  logic                        drain_ptr_reg;
  logic [PixW-1:0]             pix_reg;
  logic [WordW-1:0]            rd_idx_reg;
  drain_state_t                drain_state_reg;
  logic                        out_valid_reg;
  logic                        out_last_reg;
  logic [BitSize-1:0]          out_data_reg;

  logic                        in_ready_int;
  logic [GrpW-1:0]             grp_sel;
  logic                        grp_any;
  logic [ProcessingElements-1:0] lane_valid;
  logic [ProcessingElements-1:0] lane_en;
  logic                        wr_any;
  logic                        pix_adv;
  logic                        pix_wrap;
  logic [ProcessingElements-1:0][WordW-1:0] wr_addr;
  logic [WordW-1:0]            rd_addr;
  logic [BitSize-1:0]          bank_rdata [2];
  logic [BitSize-1:0]          rd_word;

  // A bank that is FULL or being drained cannot take new pixels.
  assign in_ready_int = !(bank_state_reg[fill_ptr_reg] == FULL ||
                          bank_state_reg[fill_ptr_reg] == DRAINING);
  assign bus.in_ready = in_ready_int;

  // Lowest group with any valid bit wins; higher groups in the same cycle
  // are dropped. Scanning downward lets the lowest match overwrite the rest.
  always_comb begin
    grp_sel    = '0;
    grp_any    = 1'b0;
    lane_valid = '0;
    for (int g = CyclesPerPixel - 1; g >= 0; g--) begin
      if (|bus.in_valid[g*ProcessingElements +: ProcessingElements]) begin
        grp_sel    = GrpW'(g);
        grp_any    = 1'b1;
        lane_valid = bus.in_valid[g*ProcessingElements +: ProcessingElements];
      end
    end
  end

  assign lane_en  = lane_valid & {ProcessingElements{in_ready_int}};
  assign wr_any   = grp_any && in_ready_int;
  // The pixel is complete once the last kernel group has been written.
  assign pix_adv  = wr_any && (grp_sel == GrpW'(CyclesPerPixel - 1));
  assign pix_wrap = pix_adv && (pix_reg == PixW'(Pixels - 1));

  // Channel-major layout: word = kernel * Pixels + pixel.
  for (genvar gi = 0; gi < ProcessingElements; gi++) begin : g_lane_addr
    assign wr_addr[gi] = WordW'((int'(grp_sel) * ProcessingElements + gi) * Pixels
                                + int'(pix_reg));
  end

  // LOAD fetches word 0; in STREAM the next word is pre-addressed so it is
  // ready to register on the handshake edge.
  assign rd_addr = (drain_state_reg == LOAD) ? '0 : rd_idx_reg + WordW'(1);

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    feature_bank #(
      .BitSize            (BitSize),
      .Words              (Words),
      .ProcessingElements (ProcessingElements),
      .AddrWidth          (WordW)
    ) u_bank (
      .clk     (clk),
      .wr_en   (lane_en & {ProcessingElements{fill_ptr_reg == 1'(gi)}}),
      .wr_addr (wr_addr),
      .wr_data (bus.in_data),
      .rd_addr (rd_addr),
      .rd_data (bank_rdata[gi])
    );
  end

  assign rd_word = bank_rdata[drain_ptr_reg];

  // Fill bookkeeping and drain FSM share one block because both update the
  // bank states. They never touch the same bank in the same cycle: the fill
  // side only writes an EMPTY/FILLING bank, the drain side a FULL/DRAINING one.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      bank_state_reg[0] <= EMPTY;
      bank_state_reg[1] <= EMPTY;
      fill_ptr_reg      <= 1'b0;
      drain_ptr_reg     <= 1'b0;
      pix_reg           <= '0;
      rd_idx_reg        <= '0;
      drain_state_reg   <= IDLE;
      out_valid_reg     <= 1'b0;
      out_last_reg      <= 1'b0;
      out_data_reg      <= '0;
    end else begin
      if (wr_any) begin
        if (pix_wrap) begin
          bank_state_reg[fill_ptr_reg] <= FULL;
          fill_ptr_reg                 <= ~fill_ptr_reg;
          pix_reg                      <= '0;
        end else begin
          if (pix_adv) begin
            pix_reg <= pix_reg + PixW'(1);
          end
          if (bank_state_reg[fill_ptr_reg] == EMPTY) begin
            bank_state_reg[fill_ptr_reg] <= FILLING;
          end
        end
      end

      case (drain_state_reg)
        IDLE: begin
          if (bank_state_reg[drain_ptr_reg] == FULL) begin
            bank_state_reg[drain_ptr_reg] <= DRAINING;
            drain_state_reg               <= LOAD;
          end
        end
        LOAD: begin
          out_valid_reg   <= 1'b1;
          out_data_reg    <= rd_word;
          out_last_reg    <= (Words == 1);
          rd_idx_reg      <= '0;
          drain_state_reg <= STREAM;
        end
        STREAM: begin
          if (out_valid_reg && bus.out_ready) begin
            if (rd_idx_reg == WordW'(Words - 1)) begin
              bank_state_reg[drain_ptr_reg] <= EMPTY;
              drain_ptr_reg                 <= ~drain_ptr_reg;
              out_valid_reg                 <= 1'b0;
              out_last_reg                  <= 1'b0;
              rd_idx_reg                    <= '0;
              if (bank_state_reg[~drain_ptr_reg] == FULL) begin
                bank_state_reg[~drain_ptr_reg] <= DRAINING;
                drain_state_reg                <= LOAD;
              end else begin
                drain_state_reg <= IDLE;
              end
            end else begin
              rd_idx_reg   <= rd_idx_reg + WordW'(1);
              out_data_reg <= rd_word;
              out_last_reg <= ((rd_idx_reg + WordW'(1)) == WordW'(Words - 1));
            end
          end
        end
        default: drain_state_reg <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;

endmodule

// File: tb/tb_feature_flattener.sv
// -----------------------------------------------------------------------------
// tb_feature_flattener
// Directed, table-driven bench for feature_flattener with default parameters
// (8 kernels, 2 lanes, 2x2 pixels, 32 words per frame).
// -----------------------------------------------------------------------------
module tb_feature_flattener;

  localparam int BitSize = 4;
  localparam int NumK    = 8;
  localparam int PE      = 2;
  localparam int FW      = 2;
  localparam int Pixels  = FW * FW;
  localparam int Words   = NumK * Pixels;
  localparam int Groups  = NumK / PE;

  logic clk = 1'b0;
  logic res_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  feature_flattener_if #(
    .BitSize(BitSize), .NumberOfK(NumK), .ProcessingElements(PE)
  ) bus ();

  feature_flattener #(
    .BitSize(BitSize), .NumberOfK(NumK), .ProcessingElements(PE), .FeatureWidth(FW)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  // One record per output word position i = k*Pixels + pix: the value driven
  // into kernel k / pixel pix, which is also the value expected at word i.
  typedef struct {
    int               k;
    int               pix;
    logic [BitSize-1:0] din;
    bit               exp_last;
  } vec_t;

  vec_t tbl [Words];

  int n_tests = 0;
  int n_fail  = 0;

  logic [BitSize-1:0] got_data [$];
  bit                 got_last [$];
  int                 got_cyc  [$];
  int                 first_valid_cyc = -1;

  logic               prev_stall = 1'b0;
  logic [BitSize-1:0] prev_data  = '0;
  logic               prev_last  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: collects accepted words and checks hold-during-stall.
  always @(negedge clk) begin
    if (res_n === 1'b1) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data",  32'(bus.out_data),  32'(prev_data));
        chk("stall_last",  32'(bus.out_last),  32'(prev_last));
      end
      if (bus.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        got_cyc.push_back(cyc);
      end
      prev_stall <= (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      prev_data  <= bus.out_data;
      prev_last  <= bus.out_last;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic fill_tbl(input int base);
    for (int i = 0; i < Words; i++) begin
      tbl[i].k        = i / Pixels;
      tbl[i].pix      = i % Pixels;
      tbl[i].din      = BitSize'((tbl[i].k + tbl[i].pix + base) % 16);
      tbl[i].exp_last = (i == Words - 1);
    end
  endtask

  // Called at posedge+1; waits (bounded) for in_ready, then presents one beat.
  task automatic drive_beat(input logic [NumK-1:0] v, input logic [BitSize-1:0] d0,
                            input logic [BitSize-1:0] d1, output int wcyc);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = v;
    bus.in_data  = {d1, d0};
    @(posedge clk); #1;
    wcyc = cyc;
    bus.in_valid = '0;
  endtask

  task automatic drive_group(input int g, input int pix, output int wcyc);
    logic [NumK-1:0] v;
    v = '0;
    v[g*PE +: PE] = '1;
    drive_beat(v, tbl[(g*PE)*Pixels + pix].din, tbl[(g*PE+1)*Pixels + pix].din, wcyc);
  endtask

  task automatic write_frame(output int last_cyc);
    for (int p = 0; p < Pixels; p++)
      for (int g = 0; g < Groups; g++)
        drive_group(g, p, last_cyc);
  endtask

  task automatic wait_words(input int n, input string name);
    int guard = 0;
    while (got_data.size() < n && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) chk({name, "_word_timeout"}, 32'(got_data.size()), 32'(n));
  endtask

  task automatic check_frame(input int start, input int count, input string name);
    int errs_before;
    errs_before = n_fail;
    for (int i = 0; i < count; i++) begin
      if (start + i < got_data.size()) begin
        chk($sformatf("%s_data[%0d]", name, i), 32'(got_data[start+i]), 32'(tbl[i].din));
        chk($sformatf("%s_last[%0d]", name, i), 32'(got_last[start+i]), 32'(tbl[i].exp_last));
      end else begin
        chk($sformatf("%s_missing[%0d]", name, i), 32'(got_data.size()), 32'(start + i + 1));
      end
    end
    $display("[TB] frame %s: %0d words compared, %0d new errors", name, count, n_fail - errs_before);
  endtask

  initial begin
    int s, wc, n0;
    logic [NumK-1:0] coll;

    res_n         = 1'b0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    res_n = 1'b1;
    @(posedge clk); #1;

    // Single frame, out_ready held high; check order, out_last, latency.
    fill_tbl(0);
    bus.out_ready   = 1'b1;
    first_valid_cyc = -1;
    s = got_data.size();
    write_frame(wc);
    wait_words(s + Words, "single");
    check_frame(s, Words, "single");
    chk("single_latency", 32'(first_valid_cyc - wc), 32'd2);
    for (int i = 1; i < Words; i++)
      if (s + i < got_cyc.size())
        chk("single_no_bubble", 32'(got_cyc[s+i] - got_cyc[s+i-1]), 32'd1);
    @(posedge clk); #1;

    // Back-pressure: out_ready toggles every cycle.
    fill_tbl(3);
    bus.out_ready = 1'b0;
    s = got_data.size();
    write_frame(wc);
    for (int t = 0; t < 400 && got_data.size() < s + Words; t++) begin
      bus.out_ready = ~bus.out_ready;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_words(s + Words, "bp");
    check_frame(s, Words, "bp");
    chk("bp_no_extra", 32'(got_data.size()), 32'(s + Words));

    // Ping-pong: two frames with no drain, then a third while draining.
    bus.out_ready = 1'b0;
    s = got_data.size();
    fill_tbl(1);
    write_frame(wc);
    fill_tbl(2);
    write_frame(wc);
    chk("pp_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("pp_out_valid_held", 32'(bus.out_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("pp_in_ready_still_low", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    fill_tbl(3);
    write_frame(wc);
    wait_words(s + 3 * Words, "pp");
    fill_tbl(1);
    check_frame(s, Words, "pp1");
    fill_tbl(2);
    check_frame(s + Words, Words, "pp2");
    fill_tbl(3);
    check_frame(s + 2 * Words, Words, "pp3");
    for (int i = 1; i < 3 * Words; i++)
      if (s + i < got_cyc.size())
        chk($sformatf("pp_gap[%0d]", i), 32'(got_cyc[s+i] - got_cyc[s+i-1]),
            ((i % Words) == 0) ? 32'd2 : 32'd1);

    // Group collision: groups 0 and 2 together must write only kernels 0/1
    // and must not advance the pixel counter.
    fill_tbl(5);
    tbl[0].din       = 4'hE;   // k0 pix0 comes only from the collision beat
    tbl[Pixels].din  = 4'hD;   // k1 pix0 likewise
    s = got_data.size();
    drive_group(1, 0, wc);
    drive_group(2, 0, wc);
    coll = '0;
    coll[0*PE +: PE] = '1;
    coll[2*PE +: PE] = '1;
    drive_beat(coll, 4'hE, 4'hD, wc);
    drive_group(3, 0, wc);
    for (int p = 1; p < Pixels; p++)
      for (int g = 0; g < Groups; g++)
        drive_group(g, p, wc);
    wait_words(s + Words, "coll");
    check_frame(s, Words, "coll");

    // Reset mid-drain after word 10.
    fill_tbl(7);
    s = got_data.size();
    write_frame(wc);
    wait_words(s + 10, "rst");
    check_frame(s, 10, "pre_rst");
    res_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_last",  32'(bus.out_last),  32'd0);
    chk("mid_rst_out_data",  32'(bus.out_data),  32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    res_n = 1'b1;
    n0 = got_data.size();
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_no_words", 32'(got_data.size()), 32'(n0));
    chk("post_rst_idle",     32'(bus.out_valid),   32'd0);
    fill_tbl(9);
    s = got_data.size();
    write_frame(wc);
    wait_words(s + Words, "after_rst");
    check_frame(s, Words, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
